// File: rtl/kim_tty_uart.sv
// Byte-stream bridge between a host UART/FIFO and the KIM-1 TTY pins (TX drives TTYI, RX samples TTYO).
// Optional: define KIM_TTY_ECHO_SUPPRESS_EN to drop RX frames that are the KIM's echo of our own TX.
module kim_tty_uart #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int unsigned STOP_BITS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       tty_line_out,
  input  logic       tty_line_in,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BIT_LAST  = CLKS_PER_BIT - 16'd1;
  localparam logic [15:0] HALF_LAST = (CLKS_PER_BIT >> 1) - 16'd1;
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  // ---------------- TX path ----------------
  state_t      tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_idx, tx_idx_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        tx_line, tx_line_d;
  logic        tx_tc, tx_last_stop, tx_accept;

  assign tx_tc        = (tx_cnt == 16'd0);
  assign tx_last_stop = (tx_state == S_STOP) && tx_tc && (tx_idx == STOP_LAST);
  // Ready during the final stop-bit terminal count lets the next start bit follow with no gap.
  assign tx_ready     = (tx_state == S_IDLE) || tx_last_stop;
  assign tx_accept    = tx_valid && tx_ready;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_tc ? BIT_LAST : tx_cnt - 16'd1;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    unique case (tx_state)
      S_IDLE:  tx_cnt_d = BIT_LAST;
      S_START: if (tx_tc) begin
        tx_state_d = S_DATA;
        tx_idx_d   = 3'd0;
      end
      S_DATA: if (tx_tc) begin
        tx_shift_d = tx_shift >> 1;
        tx_idx_d   = tx_idx + 3'd1;
        if (tx_idx == 3'd7) tx_state_d = S_STOP;
      end
      S_STOP: if (tx_tc) begin
        tx_idx_d = tx_idx + 3'd1;
        if (tx_idx == STOP_LAST) tx_state_d = S_IDLE;
      end
    endcase
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = BIT_LAST;
      tx_idx_d   = 3'd0;
      tx_shift_d = tx_data;
    end
    unique case (tx_state_d)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= BIT_LAST;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  assign tty_line_out = tx_line;

  // ---------------- RX path ----------------
  logic [1:0]  rx_sync;
  logic        rx_line, rx_prev, rx_fall;
  state_t      rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_idx, rx_idx_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic [7:0]  rx_data_d;
  logic        rx_valid_d, rx_err_d, rx_tc, rx_quiet;

  assign rx_line = rx_sync[1];
  // Edge detection also covers re-arming after a framing error: the line must go high first.
  assign rx_fall = rx_prev && !rx_line;
  assign rx_tc   = (rx_cnt == 16'd0);

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_tc ? BIT_LAST : rx_cnt - 16'd1;
    rx_idx_d   = rx_idx;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        rx_cnt_d = HALF_LAST;
        if (rx_fall) rx_state_d = S_START;
      end
      S_START: if (rx_tc) begin
        rx_state_d = rx_line ? S_IDLE : S_DATA;
        rx_idx_d   = 3'd0;
      end
      S_DATA: if (rx_tc) begin
        rx_shift_d = {rx_line, rx_shift[7:1]};
        rx_idx_d   = rx_idx + 3'd1;
        if (rx_idx == 3'd7) rx_state_d = S_STOP;
      end
      S_STOP: if (rx_tc) begin
        rx_state_d = S_IDLE;
        if (rx_line) begin
          if (!rx_quiet) rx_data_d = rx_shift;
          rx_valid_d = !rx_quiet;
        end else begin
          rx_err_d = !rx_quiet;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= HALF_LAST;
      rx_idx       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], tty_line_in};
      rx_prev      <= rx_line;
      rx_state     <= rx_state_d;
      rx_cnt       <= rx_cnt_d;
      rx_idx       <= rx_idx_d;
      rx_shift     <= rx_shift_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      rx_frame_err <= rx_err_d;
    end
  end

`ifdef KIM_TTY_ECHO_SUPPRESS_EN
  // Guard window: TX busy, or less than one bit time since TX went idle. Latched per RX start edge.
  logic [15:0] echo_guard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_guard <= 16'd0;
      rx_quiet   <= 1'b0;
    end else begin
      if (tx_state != S_IDLE)    echo_guard <= CLKS_PER_BIT;
      else if (echo_guard != 0)  echo_guard <= echo_guard - 16'd1;
      if (rx_state == S_IDLE && rx_fall)
        rx_quiet <= (tx_state != S_IDLE) || (echo_guard != 16'd0);
    end
  end
`else
  assign rx_quiet = 1'b0;
`endif

  assign busy = (tx_state != S_IDLE) || (rx_state != S_IDLE);

endmodule

// File: tb/tb_kim_tty_uart.sv
// Randomized self-checking bench for kim_tty_uart at 16 clocks/bit, 2 stop bits.
module tb_kim_tty_uart;
  localparam int CPB   = 16;
  localparam int STOPB = 2;
  localparam int FRAME = (10 + STOPB - 1) * CPB;

  logic       clk, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;
  logic       tty_line_out, tty_line_in, busy;
  logic       loop_en, rx_drv;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         got_err = 0;
  int         exp_err = 0;
  int         cmp_idx = 0;
  int         last_wait = 0;
  logic [7:0] last_good = 8'h00;

  assign tty_line_in = loop_en ? tty_line_out : rx_drv;

  kim_tty_uart #(.CLKS_PER_BIT(16'(CPB)), .STOP_BITS(STOPB)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .tty_line_out(tty_line_out), .tty_line_in(tty_line_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (rx_frame_err) got_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a byte and check the whole serial waveform plus tx_ready, cycle by cycle.
  task automatic tx_frame(input logic [7:0] b);
    int   waited;
    logic e;
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) begin
      check("tx_ready_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      return;
    end
    last_wait = waited;
    @(posedge clk);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k <= CPB)           e = 1'b0;
      else if (k <= 9 * CPB)  e = b[3'((k - CPB - 1) / CPB)];
      else                    e = 1'b1;
      check($sformatf("tx_line_c%0d", k), 32'(tty_line_out), 32'(e));
      check($sformatf("tx_ready_c%0d", k), 32'(tx_ready), 32'(k == FRAME));
    end
  endtask

  // Drive one 8N1 frame on the RX pin and record what the host should see.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int gap,
                          input logic report);
    rx_drv = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      idle(CPB);
    end
    rx_drv = stop_bit;
    idle(CPB);
    rx_drv = 1'b1;
    idle(gap);
    if (report) begin
      if (stop_bit) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic rx_compare(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_errs"}, 32'(got_err), 32'(exp_err));
    for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    cmp_idx = exp_q.size();
    check({tag, "_rx_data"}, 32'(rx_data), 32'(last_good));
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    logic       dup_report;
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;
    idle(3);
    check("rst_line", 32'(tty_line_out), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(2);

    // 'R', then a random byte back-to-back with no idle gap.
    tx_frame(8'h52);
    tx_frame(8'($urandom));
    check("tx_b2b_wait", 32'(last_wait), 32'd0);
    for (int n = 0; n < 3; n++) begin
      idle($urandom_range(0, 5));
      tx_frame(8'($urandom));
    end
    idle(1);
    check("tx_busy_after", 32'(busy), 32'd0);

    // Reset mid-frame while the line is low (all-zero byte keeps it low for 9 bit times).
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    idle($urandom_range(20, 130));
    check("pre_reset_line", 32'(tty_line_out), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_line", 32'(tty_line_out), 32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    rx_frame(8'hA5, 1'b1, 20, 1'b1);
    rx_compare("rx_a5");
    rx_frame(8'h3C, 1'b0, 20, 1'b1);
    rx_compare("rx_3c_err");
    rx_frame(8'h0D, 1'b1, 20, 1'b1);
    rx_compare("rx_0d");
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      rx_frame(b, s, $urandom_range(4, 30), 1'b1);
      rx_compare($sformatf("rx_rand%0d", n));
    end

    // Short low glitch must be rejected at the start-bit midpoint.
    rx_drv = 1'b0;
    idle(6);
    rx_drv = 1'b1;
    idle(30);
    rx_compare("glitch");
    check("glitch_busy", 32'(busy), 32'd0);

    // Full duplex: RX frame begins while TX is mid-frame.
`ifdef KIM_TTY_ECHO_SUPPRESS_EN
    dup_report = 1'b0;
`else
    dup_report = 1'b1;
`endif
    b = 8'($urandom);
    fork
      tx_frame(8'($urandom));
      begin
        idle(5);
        rx_frame(b, 1'b1, 20, dup_report);
      end
    join
    rx_compare("duplex");
    idle(40);

    // Loopback: the KIM echo of our own byte.
    loop_en = 1'b1;
    tx_frame(8'h41);
    idle(30);
    loop_en = 1'b0;
`ifndef KIM_TTY_ECHO_SUPPRESS_EN
    exp_q.push_back(8'h41);
    last_good = 8'h41;
`endif
    rx_compare("loopback");
    idle(2);
    check("end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
